// File: rtl/fan_pkg.sv
// Shared fan-path encodings, ramp FSM states and the saturating ramp step.
// FAN_KICK_EN adds the KICK state to the state encoding.
package fan_pkg;

    localparam logic [1:0] SPD_OFF  = 2'd0;
    localparam logic [1:0] SPD_LOW  = 2'd1;
    localparam logic [1:0] SPD_MID  = 2'd2;
    localparam logic [1:0] SPD_HIGH = 2'd3;

    localparam logic [7:0] DUTY_LOW_DEF  = 8'd85;
    localparam logic [7:0] DUTY_MID_DEF  = 8'd170;
    localparam logic [7:0] DUTY_HIGH_DEF = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
`ifdef FAN_KICK_EN
        ,
        ST_KICK = 2'd1
`endif
    } fan_state_e;

    // One step toward tgt; 9-bit compares keep 250+5 from wrapping past 255.
    function automatic logic [7:0] ramp_step(
        input logic [7:0] cur,
        input logic [7:0] tgt,
        input logic [8:0] step
    );
        logic [8:0] c9;
        logic [8:0] t9;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        ramp_step = tgt;
        if (t9 > c9) begin
            if (c9 + step < t9) ramp_step = cur + step[7:0];
        end else if (c9 > t9 + step) begin
            ramp_step = cur - step[7:0];
        end
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: prescaled 8-bit counter, duty latched at the period
// boundary so a duty change never produces a runt or stretched pulse.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int PWM_DIV = 50
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clr_i,
    input  logic [7:0] duty_i,
    output logic       pwm_o
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PW-1:0] pre_q;
    logic [7:0]    cnt_q;
    logic [7:0]    applied_q;
    logic          pwm_q;
    logic          pwm_tick;

    assign pwm_tick = (pre_q == PW'(PWM_DIV - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            applied_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pre_q <= pwm_tick ? '0 : pre_q + 1'b1;
            if (pwm_tick) cnt_q <= cnt_q + 8'd1;
            if (clr_i) begin
                applied_q <= '0;
                pwm_q     <= 1'b0;
            end else begin
                if (pwm_tick && cnt_q == 8'hFF) applied_q <= duty_i;
                // Full duty must not drop for the cnt==255 slot.
                pwm_q <= (applied_q == 8'hFF) || (cnt_q < applied_q);
            end
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/fan_pwm_softstart.sv
// Fan PWM stage with linear duty ramp and soft start.
// Define FAN_KICK_EN to add the full-duty kick burst before ramping.
module fan_pwm_softstart
    import fan_pkg::*;
#(
    parameter int         PWM_DIV    = 50,
    parameter int         RAMP_DIV   = 500_000,
    parameter int         RAMP_STEP  = 5,
    parameter int         KICK_TICKS = 50,
    parameter logic [7:0] DUTY_LOW   = DUTY_LOW_DEF,
    parameter logic [7:0] DUTY_MID   = DUTY_MID_DEF,
    parameter logic [7:0] DUTY_HIGH  = DUTY_HIGH_DEF
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [1:0] speed,
    input  logic       fan_en,
    output logic       pwm,
    output logic [7:0] duty,
    output logic       busy,
    output logic       running
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    fan_state_e    state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic [7:0]    target_q, target_d;
    logic [RW-1:0] rcnt_q;
    logic          ramp_tick;

`ifdef FAN_KICK_EN
    localparam int KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
    logic [KW-1:0] kick_q, kick_d;
`endif

    assign ramp_tick = (rcnt_q == RW'(RAMP_DIV - 1));

    always_comb begin
        target_d = 8'd0;
        if (fan_en) begin
            case (speed)
                SPD_LOW:  target_d = DUTY_LOW;
                SPD_MID:  target_d = DUTY_MID;
                SPD_HIGH: target_d = DUTY_HIGH;
                default:  target_d = 8'd0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
`ifdef FAN_KICK_EN
        kick_d  = kick_q;
`endif
        // Timer timeout: hard stop wins over any speed request.
        if (!fan_en) begin
            state_d = ST_IDLE;
            duty_d  = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (target_q != 8'd0) begin
`ifdef FAN_KICK_EN
                        state_d = ST_KICK;
                        duty_d  = 8'hFF;
                        kick_d  = '0;
`else
                        state_d = ST_RAMP;
`endif
                    end
                end
`ifdef FAN_KICK_EN
                ST_KICK: begin
                    if (target_q == 8'd0) begin
                        state_d = ST_RAMP;
                    end else if (ramp_tick) begin
                        if (kick_q == KW'(KICK_TICKS - 1)) state_d = ST_RAMP;
                        else kick_d = kick_q + 1'b1;
                    end
                end
`endif
                ST_RAMP: begin
                    if (duty_q == target_q) begin
                        state_d = (target_q != 8'd0) ? ST_HOLD : ST_IDLE;
                    end else if (ramp_tick) begin
                        duty_d = ramp_step(duty_q, target_q, 9'(RAMP_STEP));
                    end
                end
                ST_HOLD: begin
                    if (target_q != duty_q) state_d = ST_RAMP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= ST_IDLE;
            duty_q   <= 8'd0;
            target_q <= 8'd0;
            rcnt_q   <= '0;
`ifdef FAN_KICK_EN
            kick_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            rcnt_q   <= ramp_tick ? '0 : rcnt_q + 1'b1;
`ifdef FAN_KICK_EN
            kick_q   <= kick_d;
`endif
        end
    end

    fan_pwm_gen #(
        .PWM_DIV(PWM_DIV)
    ) u_gen (
        .clk    (clk),
        .reset_p(reset_p),
        .clr_i  (!fan_en),
        .duty_i (duty_q),
        .pwm_o  (pwm)
    );

    assign duty    = duty_q;
    assign running = (duty_q != 8'd0);
`ifdef FAN_KICK_EN
    assign busy    = (state_q == ST_RAMP) || (state_q == ST_KICK);
`else
    assign busy    = (state_q == ST_RAMP);
`endif

endmodule

// File: tb/tb_fan_pwm_softstart.sv
// Directed bench for fan_pwm_softstart: ramp sequences, kick, hard stop,
// period-boundary duty latching and a settle/duty table.
module tb_fan_pwm_softstart;

    localparam int RDIV = 4;
    localparam int STEP = 5;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       fan_en = 1'b1;
    logic       pwm;
    logic [7:0] duty;
    logic       busy;
    logic       running;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fan_pwm_softstart #(
        .PWM_DIV   (1),
        .RAMP_DIV  (RDIV),
        .RAMP_STEP (STEP),
        .KICK_TICKS(3)
    ) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .speed  (speed),
        .fan_en (fan_en),
        .pwm    (pwm),
        .duty   (duty),
        .busy   (busy),
        .running(running)
    );

    typedef struct {
        logic       en;
        logic [1:0] spd;
        int         exp_duty;
        logic       exp_run;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_change(input int bound, output int n, output bit ok);
        logic [7:0] last;
        last = duty;
        n = 0;
        while (duty === last && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (duty !== last);
    endtask

    // Expect duty to walk from 'from' to 'to' one ramp tick at a time.
    task automatic ramp_seq(input int from, input int to, input bit chk_first,
                            input string nm);
        int v;
        int n;
        bit ok;
        bit first;
        v = from;
        first = !chk_first;
        while (v != to) begin
            if (to > v) v = (v + STEP > to) ? to : v + STEP;
            else v = (v - STEP < to) ? to : v - STEP;
            wait_change(first ? 64 : 3 * RDIV, n, ok);
            chk(nm, duty, v);
            if (!ok) return;
            if (!first) chk({nm, "_interval"}, n, RDIV);
            first = 1'b0;
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        tick(3);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_settle_busy"}, busy, 0);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm === 1'b1) h++;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int  n;
        int  h;
        int  len;
        bit  ok;
        logic prev;

        vecs[0] = '{1'b1, 2'd1, 85, 1'b1};
        vecs[1] = '{1'b1, 2'd3, 255, 1'b1};
        vecs[2] = '{1'b1, 2'd2, 170, 1'b1};
        vecs[3] = '{1'b0, 2'd2, 0, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 0, 1'b0};
        vecs[5] = '{1'b1, 2'd3, 255, 1'b1};
        vecs[6] = '{1'b1, 2'd0, 0, 1'b0};

        tick(2);
        chk("rst_duty", duty, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_running", running, 0);
        reset_p = 1'b0;
        tick(3);
        chk("idle_duty", duty, 0);

`ifdef FAN_KICK_EN
        speed = 2'd1;
        tick(2);
        chk("kick_duty", duty, 255);
        chk("kick_busy", busy, 1);
        wait_change(64, n, ok);
        chk("kick_len_ok", (n >= 13 && n <= 16), 1);
        chk("kick_first_step", duty, 250);
        ramp_seq(250, 85, 1'b1, "kick_down");
`else
        speed = 2'd2;
        tick(2);
        chk("nokick_duty", duty, 0);
        chk("nokick_busy", busy, 1);
        ramp_seq(0, 170, 1'b0, "nokick_up");
        speed = 2'd1;
        ramp_seq(170, 85, 1'b0, "mid_to_low");
`endif
        tick(2);
        chk("hold85_busy", busy, 0);
        chk("hold85_running", running, 1);

        speed = 2'd3;
        ramp_seq(85, 255, 1'b0, "up_high");
        tick(260);
        count_high(256, h);
        chk("pwm_full_const", h, 256);

        speed = 2'd2;
        ramp_seq(255, 170, 1'b0, "high_to_mid");
        tick(2);
        chk("hold170_busy", busy, 0);

        n = 0;
        while (pwm !== 1'b0 && n < 600) begin @(negedge clk); n++; end
        while (pwm !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        chk("pwm_rise_found", (n < 600), 1);
        prev = 1'b1;
        len = 0;
        h = 0;
        while (len < 400) begin
            if (pwm === 1'b1 && prev === 1'b0) break;
            if (pwm === 1'b1) h++;
            prev = pwm;
            len++;
            if (len == 100) speed = 2'd1;
            @(negedge clk);
        end
        chk("pwm_period_len", len, 256);
        chk("pwm_high_latched", h, 170);
        wait_idle("after_latch");
        chk("after_latch_duty", duty, 85);

        speed = 2'd3;
        n = 0;
        while (duty !== 8'd120 && n < 200) begin @(negedge clk); n++; end
        chk("reach_120", duty, 120);
        fan_en = 1'b0;
        speed = 2'd2;
        tick(1);
        chk("stop_duty", duty, 0);
        chk("stop_pwm", pwm, 0);
        chk("stop_busy", busy, 0);
        chk("stop_running", running, 0);
        tick(5);
        chk("stop_stays", duty, 0);
        fan_en = 1'b1;
        tick(2);
`ifdef FAN_KICK_EN
        chk("rekick_duty", duty, 255);
        chk("rekick_busy", busy, 1);
        wait_idle("rekick");
        chk("rekick_final", duty, 170);
`else
        chk("restart_duty", duty, 0);
        chk("restart_busy", busy, 1);
        ramp_seq(0, 170, 1'b0, "restart_up");
`endif

        speed = 2'd0;
        ramp_seq(170, 0, 1'b0, "down_off");
        tick(2);
        chk("off_busy", busy, 0);
        chk("off_running", running, 0);
        tick(260);
        count_high(256, h);
        chk("off_pwm_low", h, 0);

        for (int i = 0; i < 7; i++) begin
            fan_en = vecs[i].en;
            speed = vecs[i].spd;
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_duty", i), duty, vecs[i].exp_duty);
            chk($sformatf("vec%0d_running", i), running, vecs[i].exp_run);
            tick(260);
            count_high(256, h);
            chk($sformatf("vec%0d_pwm_high", i), h,
                (vecs[i].exp_duty == 255) ? 256 : vecs[i].exp_duty);
        end

        fan_en = 1'b1;
        speed = 2'd2;
        tick(40);
        chk("pre_reset_busy", busy, 1);
        #2 reset_p = 1'b1;
        #1;
        chk("async_rst_duty", duty, 0);
        chk("async_rst_pwm", pwm, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_running", running, 0);
        @(negedge clk);
        reset_p = 1'b0;
        chk("post_rst_duty", duty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
